sub_share_arb: RTL
==================

Name: sub_share_arb

Overview:
- Round-robin arbiter and scheduler that shares one 8-bit subtract/overflow datapath between N_REQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- Exactly one request is granted per cycle. Its result (a-b, signed overflow, borrow-out, requester id) goes into a single registered response slot with valid/ready backpressure.
- Sits between arithmetic clients (ALU lanes, DSP tasks) and the shared subtract resource.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(N_REQ), width of the requester id field (derived; not overridden).
- CNT_W, 8, width of the saturating overflow-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester grant/accept; one-hot or zero.
- req_a  input  8*N_REQ  minuends; requester k uses bits [8k+7:8k].
- req_b  input  8*N_REQ  subtrahends, same packing.
- rsp_valid  output  1  response slot occupied.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of the requester that produced the response.
- rsp_diff  output  8  a - b, modulo 256.
- rsp_overflow  output  1  two's-complement signed overflow of a - b.
- rsp_borrow  output  1  unsigned borrow-out (1 when a < b unsigned).
- ovf_count  output  CNT_W  saturating count of accepted results with overflow=1.
- ovf_clear  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0; rsp_id, rsp_diff, rsp_overflow, rsp_borrow=0.
  - ovf_count=0; rr pointer=0.
  - req_ready=0 while in reset.
- Slot free condition: slot_free = !rsp_valid || rsp_ready. It depends combinationally on rsp_ready.
- Arbitration (combinational):
  - When slot_free, grant the first requester with req_valid=1, searching from index ptr upward and wrapping modulo N_REQ.
  - req_ready[g]=1 for that requester only. All bits are 0 if no request is pending or the slot is not free.
  - req_ready never depends on req_a or req_b.
- Handshake:
  - Transfer occurs when req_valid[k] && req_ready[k].
  - Requesters hold valid, a and b stable until accepted.
  - Dropping an unaccepted request is permitted; it is simply not granted.
- Pointer update: on a transfer from g, ptr <= (g+1) mod N_REQ. With no transfer, ptr holds.
- Datapath (combinational on the granted operands, registered into the slot):
  - diff = a + ~b + 1, truncated to 8 bits.
  - borrow = (a < b) unsigned.
  - overflow = (a[7]^b[7]) & (diff[7]^a[7]).
- Latency: one cycle. A request accepted at edge n is visible on rsp_* after edge n.
- Slot update rules:
  - Transfer: load rsp_* and set rsp_valid=1. This also applies when the old response is consumed in the same cycle (back-to-back throughput of 1 per cycle).
  - No transfer and rsp_ready=1: clear rsp_valid.
  - rsp_valid=1 and rsp_ready=0: hold all rsp_* stable and keep req_ready=0.
- ovf_count:
  - Increments when a response with rsp_overflow=1 is consumed (rsp_valid && rsp_ready).
  - Saturates at 2^CNT_W-1.
  - ovf_clear has priority over increment; clear and increment in the same cycle gives 0.
- Boundaries:
  - All requesters valid continuously: grants cycle 0,1,...,N_REQ-1,0 (starvation-free).
  - Single requester: granted every cycle while the slot is free.
  - Reset asserted mid-stream: a pending response is discarded and ptr returns to 0.
  - rsp_ready high with rsp_valid low: no effect.
- No X propagation: unused id bits are 0 when N_REQ is not a power of 2.

Decomposition:
- Shared package sub_share_pkg holds:
  - OPW=8 constant.
  - Packed struct sub_rsp_t {id, diff, overflow, borrow}.
  - Function sub_calc(a,b) returning {diff, overflow, borrow}, reused by the bench scoreboard.
- One natural sub-module: rr_arbiter (parameterised N, req/grant vectors, ptr update on accept), reusable elsewhere.
- Datapath, slot register and counter stay in the top module.

Test Plan:
- Arithmetic corners, single requester 0, rsp_ready=1:
  - a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow=0.
  - a=0x00, b=0x01 -> diff=0xFF, overflow=0, borrow=1.
  - a=0x7F, b=0xFF -> diff=0x80, overflow=1, borrow=1.
  - a=0x55, b=0x55 -> diff=0x00, overflow=0, borrow=0.
- Fairness: from reset, all four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one response per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> rsp_* frozen, req_ready=0. On rsp_ready=1, the next grant goes to the pointer-next requester in the same cycle.
- Sparse requests: only requesters 1 and 3 valid, ptr=2 -> grant 3 then 1. Also check that a requester dropping valid before grant is never reported.
- Counter: 300 overflow responses -> ovf_count saturates at 255. ovf_clear asserted together with an overflow consume -> count reads 0.
- Reset mid-op: rst_n low while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately (asynchronously). After release, first grant goes to the lowest-index valid requester (ptr=0).

Source files
------------

// File: rtl/sub_share_pkg.sv
// sub_share_pkg: shared constants, response struct and subtract helper for sub_share_arb
//   OPW       operand width
//   sub_res_t {diff, overflow, borrow} produced by sub_calc
//   sub_rsp_t response slot contents; id sized for the largest legal N_REQ (8)
package sub_share_pkg;
   localparam int OPW = 8;
   localparam int MAX_ID_W = 3;
   typedef struct packed {
      logic [OPW-1:0] diff;
      logic           overflow;
      logic           borrow;
   } sub_res_t;
   typedef struct packed {
      logic [MAX_ID_W-1:0] id;
      logic [OPW-1:0]      diff;
      logic                overflow;
      logic                borrow;
   } sub_rsp_t;
   function automatic sub_res_t sub_calc(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
      sub_res_t r;
      r.diff     = a + ~b + 8'd1;
      r.borrow   = a < b;
      r.overflow = (a[OPW-1] ^ b[OPW-1]) & (r.diff[OPW-1] ^ a[OPW-1]);
      return r;
   endfunction
endpackage

// File: rtl/sub_share_arb_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr; ptr moves past the winner on each grant
//   clk, rst_n  clock, async active-low reset (ptr returns to 0)
//   en          grant allowed this cycle
//   req         request vector
//   grant       one-hot or zero grant (every grant is an accepted transfer)
//   gidx        index of the granted requester (0 when none)
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] gidx
);
   logic [IW-1:0] ptr;
   logic [IW-1:0] k;
   logic          found;
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
         k = IW'((int'(ptr) + i) % N);
         if (en && !found && req[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            gidx     = k;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else if (found) ptr <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
   end
endmodule

// File: rtl/sub_share_arb.sv
// sub_share_arb: round-robin sharing of one 8-bit subtract/overflow unit among N_REQ requesters
//   req_valid/req_ready/req_a/req_b  per-requester operand handshake (8 bits per lane)
//   rsp_valid/rsp_ready              single registered response slot
//   rsp_id/rsp_diff/rsp_overflow/rsp_borrow  result fields
//   ovf_count/ovf_clear              saturating count of consumed overflow results
module sub_share_arb
   import sub_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ),
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [8*N_REQ-1:0] req_a,
   input  logic [8*N_REQ-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [7:0]         rsp_diff,
   output logic               rsp_overflow,
   output logic               rsp_borrow,
   output logic [CNT_W-1:0]   ovf_count,
   input  logic               ovf_clear
);
   logic [ID_W-1:0] gidx;
   logic [OPW-1:0]  ga, gb;
   logic            xfer;
   sub_res_t        res;
   sub_rsp_t        slot;
   // rst_n gating keeps req_ready low for the whole reset assertion
   rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (rst_n && (!rsp_valid || rsp_ready)),
      .req  (req_valid),
      .grant(req_ready),
      .gidx (gidx)
   );
   assign xfer = |req_ready;
   assign ga   = req_a[OPW*int'(gidx) +: OPW];
   assign gb   = req_b[OPW*int'(gidx) +: OPW];
   assign res  = sub_calc(ga, gb);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         slot      <= '0;
         ovf_count <= '0;
      end else begin
         if (xfer) begin
            rsp_valid     <= 1'b1;
            slot.id       <= MAX_ID_W'(gidx);
            slot.diff     <= res.diff;
            slot.overflow <= res.overflow;
            slot.borrow   <= res.borrow;
         end else if (rsp_ready) rsp_valid <= 1'b0;
         if (ovf_clear) ovf_count <= '0;
         else if (rsp_valid && rsp_ready && slot.overflow && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
      end
   end
   assign rsp_id       = slot.id[ID_W-1:0];
   assign rsp_diff     = slot.diff;
   assign rsp_overflow = slot.overflow;
   assign rsp_borrow   = slot.borrow;
endmodule
